// File: rtl/fetch_stage.sv
// MIPS IF stage + IF/ID register: owns pc, fetches from icache; ID valid one cycle after ihit.
// Stalls on hazard, squashes on branch/jump, parks a redirect across an icache miss, stops on HALT_OP.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        hazard,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_npc,
    output logic        id_valid,
    output logic        halted
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_npc;
    logic        r_id_valid;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;
    logic        r_imem_ren;
    logic        r_halted;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_halt_go;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = r_id_valid & ~hazard & (jump | branch);
    assign w_target   = jump ? jump_target : branch_target;
    assign w_halt_go  = r_id_valid & ~hazard & (r_id_instr[31:26] == HALT_OP);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= FETCH;
            r_pc         <= PC_INIT;
            r_id_instr   <= 32'd0;
            r_id_npc     <= 32'd0;
            r_id_valid   <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'd0;
            r_imem_ren   <= 1'b1;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // Under hazard everything holds; a word returned now is refetched since pc is unchanged.
                    if (!hazard) begin
                        if (w_halt_go) begin
                            r_state    <= HALTED;
                            r_imem_ren <= 1'b0;
                            r_halted   <= 1'b1;
                            r_id_valid <= 1'b0;
                            r_id_instr <= 32'd0;
                        end else if (w_redirect && ihit) begin
                            r_pc       <= w_target;
                            r_id_valid <= 1'b0;
                            r_id_instr <= 32'd0;
                        end else if (w_redirect) begin
                            // Miss in flight at the old pc: remember the target until it completes.
                            r_redir_pend <= 1'b1;
                            r_redir_pc   <= w_target;
                            r_id_valid   <= 1'b0;
                            r_id_instr   <= 32'd0;
                        end else if (r_redir_pend && ihit) begin
                            r_pc         <= r_redir_pc;
                            r_redir_pend <= 1'b0;
                            r_id_valid   <= 1'b0;
                            r_id_instr   <= 32'd0;
                        end else if (ihit) begin
                            r_id_instr <= imemload;
                            r_id_npc   <= w_pc_plus4;
                            r_id_valid <= 1'b1;
                            r_pc       <= w_pc_plus4;
                        end else begin
                            r_id_valid <= 1'b0;
                            r_id_instr <= 32'd0;
                        end
                    end
                end
                HALTED: begin
                    r_imem_ren <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imemREN  = r_imem_ren;
    assign imemaddr = r_pc;
    assign id_instr = r_id_instr;
    assign id_npc   = r_id_npc;
    assign id_valid = r_id_valid;
    assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by randomized traffic against a reference model.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        hazard;
    logic        branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] id_instr;
    logic [31:0] id_npc;
    logic        id_valid;
    logic        halted;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .hazard(hazard),
        .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .id_instr(id_instr), .id_npc(id_npc), .id_valid(id_valid), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] load;
        logic        haz;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        e_ren;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (what the fetch stage should hold after each edge).
    logic [31:0] m_pc, m_instr, m_npc, m_pendpc;
    logic        m_valid, m_halted, m_pend;

    task automatic add(input logic rst, input logic ih, input logic [31:0] ld,
                       input logic hz, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic ren, input logic [31:0] addr, input logic [31:0] ins,
                       input logic [31:0] npc, input logic vld, input logic hlt);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.load = ld; v.haz = hz; v.br = br; v.bt = bt;
        v.jp = jp; v.jt = jt; v.e_ren = ren; v.e_addr = addr; v.e_instr = ins;
        v.e_npc = npc; v.e_valid = vld; v.e_halted = hlt;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ih, input logic [31:0] ld,
                         input logic hz, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        @(negedge CLK);
        RST = rst; ihit = ih; imemload = ld; hazard = hz;
        branch = br; branch_target = bt; jump = jp; jump_target = jt;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ren, input logic [31:0] addr,
                             input logic [31:0] ins, input logic [31:0] npc,
                             input logic vld, input logic hlt);
        check({tag, ".imemREN"},  {31'd0, imemREN},  {31'd0, ren});
        check({tag, ".imemaddr"}, imemaddr, addr);
        check({tag, ".id_instr"}, id_instr, ins);
        check({tag, ".id_npc"},   id_npc,   npc);
        check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, vld});
        check({tag, ".halted"},   {31'd0, halted},   {31'd0, hlt});
    endtask

    // Spec-level model: classify what the ID instruction and fetched word do this cycle.
    task automatic model_step(input logic rst, input logic ih, input logic [31:0] ld,
                              input logic hz, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt);
        logic        id_live;
        logic [5:0]  id_op;
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
            m_halted = 1'b0; m_pend = 1'b0; m_pendpc = 32'd0;
            return;
        end
        if (m_halted || hz) return;
        id_live = m_valid;
        id_op   = m_instr[31:26];
        m_valid = 1'b0;
        m_instr = 32'd0;
        if (id_live && id_op == 6'b111111) begin
            m_halted = 1'b1;
        end else if (id_live && (br || jp)) begin
            if (ih) m_pc = jp ? jt : bt;
            else begin
                m_pend   = 1'b1;
                m_pendpc = jp ? jt : bt;
            end
        end else if (ih && m_pend) begin
            m_pc   = m_pendpc;
            m_pend = 1'b0;
        end else if (ih) begin
            m_instr = ld;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'h1F00_0006;
    localparam logic [31:0] WG = 32'h2000_0007, WH = 32'hFC00_0000, WJ = 32'h3BAD_BAD0;
    localparam logic [31:0] WI = 32'h4000_0009, WK = 32'h5000_000A, WL = 32'h6000_000B;
    localparam logic [31:0] WH2 = 32'hFC00_0001;

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = 32'd0; hazard = 1'b0;
        branch = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;

        //   rst ih load  hz br bt        jp jt            ren addr          instr npc           v  h
        add(1, 0, 0,   0, 0, 0,        0, 0,            1, 32'h0,         0,   32'h0,        0, 0);
        add(0, 1, WA,  0, 0, 0,        0, 0,            1, 32'h4,         WA,  32'h4,        1, 0);
        add(0, 1, WB,  0, 0, 0,        0, 0,            1, 32'h8,         WB,  32'h8,        1, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            1, 32'h8,         0,   32'h8,        0, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            1, 32'h8,         0,   32'h8,        0, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            1, 32'h8,         0,   32'h8,        0, 0);
        add(0, 1, WC,  0, 0, 0,        0, 0,            1, 32'hC,         WC,  32'hC,        1, 0);
        add(0, 1, WD,  1, 0, 0,        0, 0,            1, 32'hC,         WC,  32'hC,        1, 0);
        add(0, 1, WD,  1, 0, 0,        0, 0,            1, 32'hC,         WC,  32'hC,        1, 0);
        add(0, 1, WD,  0, 0, 0,        0, 0,            1, 32'h10,        WD,  32'h10,       1, 0);
        add(0, 1, WJ,  0, 1, 32'h40,   0, 0,            1, 32'h40,        0,   32'h10,       0, 0);
        add(0, 1, WE,  0, 0, 0,        0, 0,            1, 32'h44,        WE,  32'h44,       1, 0);
        add(0, 1, WJ,  0, 1, 32'h40,   1, 32'h80,       1, 32'h80,        0,   32'h44,       0, 0);
        add(0, 1, WF,  0, 0, 0,        0, 0,            1, 32'h84,        WF,  32'h84,       1, 0);
        add(0, 0, WJ,  0, 0, 0,        1, 32'h100,      1, 32'h84,        0,   32'h84,       0, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            1, 32'h84,        0,   32'h84,       0, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            1, 32'h84,        0,   32'h84,       0, 0);
        add(0, 1, WJ,  0, 0, 0,        0, 0,            1, 32'h100,       0,   32'h84,       0, 0);
        add(0, 1, WG,  0, 0, 0,        0, 0,            1, 32'h104,       WG,  32'h104,      1, 0);
        add(0, 1, WH,  0, 0, 0,        0, 0,            1, 32'h108,       WH,  32'h108,      1, 0);
        add(0, 1, WJ,  0, 0, 0,        0, 0,            0, 32'h108,       0,   32'h108,      0, 1);
        add(0, 1, WA,  1, 1, 32'h40,   1, 32'h80,       0, 32'h108,       0,   32'h108,      0, 1);
        add(1, 0, 0,   0, 0, 0,        0, 0,            1, 32'h0,         0,   32'h0,        0, 0);
        add(0, 1, WI,  0, 0, 0,        0, 0,            1, 32'h4,         WI,  32'h4,        1, 0);
        add(0, 0, WJ,  0, 0, 0,        1, 32'h200,      1, 32'h4,         0,   32'h4,        0, 0);
        add(1, 0, 0,   0, 0, 0,        0, 0,            1, 32'h0,         0,   32'h0,        0, 0);
        add(0, 1, WK,  0, 0, 0,        0, 0,            1, 32'h4,         WK,  32'h4,        1, 0);
        add(0, 1, WJ,  0, 0, 0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0,   32'h4,        0, 0);
        add(0, 1, WL,  0, 0, 0,        0, 0,            1, 32'h0,         WL,  32'h0,        1, 0);
        add(0, 1, WH2, 0, 0, 0,        0, 0,            1, 32'h4,         WH2, 32'h4,        1, 0);
        add(0, 1, WJ,  1, 0, 0,        0, 0,            1, 32'h4,         WH2, 32'h4,        1, 0);
        add(0, 0, WJ,  0, 0, 0,        0, 0,            0, 32'h4,         0,   32'h4,        0, 1);
        add(1, 0, 0,   0, 0, 0,        0, 0,            1, 32'h0,         0,   32'h0,        0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ihit, tbl[i].load, tbl[i].haz,
                  tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt);
            check_all($sformatf("vec%0d", i), tbl[i].e_ren, tbl[i].e_addr,
                      tbl[i].e_instr, tbl[i].e_npc, tbl[i].e_valid, tbl[i].e_halted);
        end

        // Randomized traffic; the last vector left the DUT in reset state.
        model_step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_ih, r_hz, r_br, r_jp;
            logic [31:0] r_ld, r_bt, r_jt;
            r_rst = ($urandom_range(0, 59) == 0);
            r_ih  = ($urandom_range(0, 9) < 7);
            r_hz  = ($urandom_range(0, 9) < 2);
            r_br  = ($urandom_range(0, 3) == 0);
            r_jp  = ($urandom_range(0, 6) == 0);
            r_ld  = $urandom;
            if ($urandom_range(0, 39) == 0) r_ld[31:26] = 6'b111111;
            else if (r_ld[31:26] == 6'b111111) r_ld[31] = 1'b0;
            r_bt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_jt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(r_rst, r_ih, r_ld, r_hz, r_br, r_bt, r_jp, r_jt);
            model_step(r_rst, r_ih, r_ld, r_hz, r_br, r_bt, r_jp, r_jt);
            check_all($sformatf("rnd%0d", c), ~m_halted, m_pc, m_instr, m_npc, m_valid, m_halted);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core. It owns the PC and drives the instruction-cache request. It latches fetched instructions into the ID stage. It consumes the hazard unit's hazard/branch/jump outputs to stall, redirect and flush. A pending-redirect register keeps a branch/jump resolved during an icache miss until the miss completes.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
HALT_OP, 6'b111111, opcode that stops fetch once it leaves ID

Ports:
CLK  in  1  core clock
RST  in  1  synchronous, active-high reset
ihit  in  1  icache returns imemload for imemaddr this cycle
imemload  in  32  instruction data from icache
imemREN  out  1  icache read enable
imemaddr  out  32  icache address (= pc)
hazard  in  1  stall request from hazard unit (ID instruction must hold)
branch  in  1  taken branch resolved in ID
branch_target  in  32  taken-branch PC
jump  in  1  J/JAL/JR resolved in ID
jump_target  in  32  jump PC
id_instr  out  32  IF/ID instruction
id_npc  out  32  IF/ID PC+4 of id_instr
id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
halted  out  1  fetch permanently stopped

Behaviour:
- All state updates on posedge CLK. RST is synchronous and has priority over everything.
- Reset values: pc=PC_INIT, id_instr=0, id_npc=0, id_valid=0, redir_pend=0, redir_pc=0, state=FETCH, halted=0.
- States:
  - FETCH: imemREN=1.
  - HALTED: imemREN=0, sticky until RST.
  - imemaddr=pc in both states. halted=(state==HALTED).
- redirect = id_valid & !hazard & (jump|branch). target = jump ? jump_target : branch_target (jump wins).
- halt_go = id_valid & !hazard & id_instr[31:26]==HALT_OP.
- FETCH priority, first match wins:
  1. hazard=1: pc, ID register and redir_pend hold. Any instruction returned that cycle is dropped and refetched later because pc is unchanged.
  2. halt_go: state<=HALTED. ID<=bubble (id_valid=0, id_instr=0). The fetched word is dropped and pc holds.
  3. redirect & ihit: pc<=target; ID<=bubble, which squashes the wrong-path word.
  4. redirect & !ihit: redir_pend<=1, redir_pc<=target; ID<=bubble. The cache request continues unchanged at the old pc.
  5. redir_pend & ihit: pc<=redir_pc, redir_pend<=0, returned word dropped; ID<=bubble.
  6. ihit: id_instr<=imemload, id_npc<=pc+4, id_valid<=1, pc<=pc+4.
  7. otherwise (miss, no hazard): ID<=bubble, pc holds.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. No alignment checking.
- A second redirect while redir_pend=1 cannot occur, because ID is a bubble.
- HALTED: pc, redir_pend and ID frozen; id_valid=0. ihit, hazard, branch and jump are ignored.
- Latency:
  - Instruction visible in ID one cycle after its ihit.
  - Redirect with ihit: target fetched the next cycle.
  - Redirect during a miss: target address presented the cycle after the miss completes.
- RST asserted mid-miss or with redir_pend=1: everything returns to reset values. No pending state survives.

Test Plan:
- Sequential fetch, PC_INIT=0, ihit=1 every cycle, words A,B,C -> imemaddr 0,4,8; id_instr A,B,C one cycle later; id_npc 4,8,C; id_valid=1.
- Miss: ihit=0 for 3 cycles at pc=8, then 1 -> id_valid=0 for 3 cycles; pc stays 8; then id_instr=word@8, pc=C.
- Stall: hazard=1 for 2 cycles with ihit=1 -> id_instr, id_npc and pc unchanged; after release the same pc word is latched.
- Taken branch: id_valid=1, branch=1, branch_target=0x40, ihit=1 -> next cycle pc=0x40, id_valid=0; the following cycle id_instr=word@0x40. Jump and branch both asserted with jump_target=0x80 -> pc=0x80.
- Jump during miss: jump=1, jump_target=0x100, ihit=0 for 2 more cycles -> redir_pend=1, pc unchanged. On ihit the word is dropped, then pc=0x100 and redir_pend=0. Assert RST mid-miss in a second run -> pc=PC_INIT, redir_pend=0, id_valid=0.
- Halt: HALT_OP word reaches ID with hazard=0 -> next cycle halted=1, imemREN=0, id_valid=0. Further ihit, branch and jump have no effect; RST returns to FETCH.
